// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART byte FIFO of the 8051 MCU core.
//   UART_FIFO_DEPTH / UART_FIFO_ADDR_W : default FIFO geometry
//   UART_FIFO_AF_LEVEL / _AE_LEVEL     : default almost-full/empty thresholds
//   fifo_ptr_t                         : wrap bit + address bits pointer
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_FIFO_ADDR_W   = 4;
    localparam int UART_FIFO_DEPTH    = 1 << UART_FIFO_ADDR_W;
    localparam int UART_FIFO_AF_LEVEL = 14;
    localparam int UART_FIFO_AE_LEVEL = 2;

    // MSB is the wrap bit, the low UART_FIFO_ADDR_W bits address the RAM.
    typedef logic [UART_FIFO_ADDR_W:0] fifo_ptr_t;

endpackage : uart_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Free-running FIFO pointer: increments on inc, returns to 0 on clr (clr wins).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance the pointer by one at the next edge
//   clr        : return the pointer to 0 at the next edge
//   ptr        : full pointer value (wrap bit + address)
//   wrap       : pointer MSB, toggles every time the address rolls over
//   addr       : RAM address bits
// -----------------------------------------------------------------------------
module fifo_ptr
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH:0]   ptr,
    output logic                  wrap,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // Counts freely through 2**(ADDR_WIDTH+1); the natural rollover is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

    assign wrap = ptr[ADDR_WIDTH];
    assign addr = ptr[ADDR_WIDTH-1:0];

endmodule : fifo_ptr

// File: rtl/uart_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_fifo_ctrl
// Pointer and flag controller for the UART byte FIFO. Holds no data: push data
// goes straight into fifo_ram, pop data comes straight out of fifo_ram.
//
// Optional feature macro: UART_FIFO_LEVEL_FLAGS_EN adds the AF_LEVEL/AE_LEVEL
// thresholds and the registered almost_full/almost_empty outputs.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   wr_req / rd_req        : push / pop requests
//   flush                  : discard all contents at the next edge
//   err_clr                : clear the sticky overflow/underflow flags
//   ram_w_en, ram_w_addr   : fifo_ram write port (combinational)
//   ram_r_en, ram_r_addr   : fifo_ram read port (combinational)
//   rd_valid               : fifo_ram r_data holds the popped byte
//   full, empty, count     : occupancy status
//   overflow, underflow    : sticky rejected-push / rejected-pop flags
//   almost_full/_empty     : threshold flags (macro builds only)
//
// Request semantics: a request is a single-cycle level sampled at the edge.
// A push is accepted when wr_req & ~full & ~flush, a pop when
// rd_req & ~empty & ~flush, both judged on this cycle's flags; the accept is
// visible immediately on ram_w_en/ram_r_en and the pointer moves at the edge.
// A request that is not accepted is dropped (no retry) and, outside a flush
// cycle, raises the matching sticky error.
// -----------------------------------------------------------------------------
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_W
`ifdef UART_FIFO_LEVEL_FLAGS_EN
    ,
    parameter int AF_LEVEL   = UART_FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = UART_FIFO_AE_LEVEL
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef UART_FIFO_LEVEL_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("uart_fifo_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH:0]   w_ptr;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic                  w_wrap;
    logic                  r_wrap;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  ovf_set;
    logic                  udf_set;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ram_w_en),
        .clr   (flush),
        .ptr   (w_ptr),
        .wrap  (w_wrap),
        .addr  (w_addr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ram_r_en),
        .clr   (flush),
        .ptr   (r_ptr),
        .wrap  (r_wrap),
        .addr  (r_addr)
    );

    // Status straight from the pointer registers.
    assign empty = (w_ptr == r_ptr);
    assign full  = (w_wrap != r_wrap) && (w_addr == r_addr);
    assign count = w_ptr - r_ptr;

    // Full gates the push and empty gates the pop, so full+push+pop pops only
    // and empty+push+pop pushes only (no read-through of the byte in flight).
    assign ram_w_en   = wr_req & ~full  & ~flush;
    assign ram_r_en   = rd_req & ~empty & ~flush;
    assign ram_w_addr = w_addr;
    assign ram_r_addr = r_addr;

    assign ovf_set = wr_req & full  & ~flush;
    assign udf_set = rd_req & empty & ~flush;

    // rd_valid lines up with the one-cycle fifo_ram read latency.
    // For the sticky flags a new set beats a simultaneous err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= ram_r_en;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_LEVEL_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [ADDR_WIDTH:0] AF_CNT  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT  = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] count_next;

    // Occupancy after this edge, so the flags register in step with the pointers.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (ram_w_en && !ram_r_en) begin
            count_next = count + CNT_ONE;
        end else if (!ram_w_en && ram_r_en) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
        end
    end
`endif

endmodule : uart_fifo_ctrl

// File: tb/tb_uart_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_ctrl
// Self-checking bench for uart_fifo_ctrl. A behavioural fifo_ram sits on the
// DUT's RAM ports; pushed bytes go into exp_q and are compared when rd_valid
// presents the popped byte. A reference pointer model predicts every flag.
// -----------------------------------------------------------------------------
module tb_uart_fifo_ctrl;
    import uart_pkg::*;

    localparam int AW = UART_FIFO_ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          ram_w_en;
    logic [AW-1:0] ram_w_addr;
    logic          ram_r_en;
    logic [AW-1:0] ram_r_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`ifdef UART_FIFO_LEVEL_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    uart_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .flush        (flush),
        .err_clr      (err_clr),
        .ram_w_en     (ram_w_en),
        .ram_w_addr   (ram_w_addr),
        .ram_r_en     (ram_r_en),
        .ram_r_addr   (ram_r_addr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef UART_FIFO_LEVEL_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // ---------------- behavioural fifo_ram ----------------
    logic [7:0] mem [UART_FIFO_DEPTH];
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= w_data;
        if (ram_r_en) r_data <= mem[ram_r_addr];
    end

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    fifo_ptr_t m_w, m_r;
    logic m_ovf, m_udf, m_rdv, m_af, m_ae;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_full();
        fifo_ptr_t wrap_only;
        wrap_only = {1'b1, {AW{1'b0}}};
        return ((m_w ^ m_r) == wrap_only);
    endfunction

    function automatic logic m_empty();
        return (m_w == m_r);
    endfunction

    function automatic fifo_ptr_t m_count();
        return fifo_ptr_t'(m_w - m_r);
    endfunction

    task automatic model_reset();
        m_w = '0; m_r = '0;
        m_ovf = 1'b0; m_udf = 1'b0; m_rdv = 1'b0;
        m_af = 1'b0; m_ae = 1'b1;
        exp_q.delete();
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic compare_all();
        check("ram_w_en",   32'(ram_w_en),   32'(wr_req & ~m_full() & ~flush));
        check("ram_r_en",   32'(ram_r_en),   32'(rd_req & ~m_empty() & ~flush));
        check("ram_w_addr", 32'(ram_w_addr), 32'(m_w[AW-1:0]));
        check("ram_r_addr", 32'(ram_r_addr), 32'(m_r[AW-1:0]));
        check("full",       32'(full),       32'(m_full()));
        check("empty",      32'(empty),      32'(m_empty()));
        check("count",      32'(count),      32'(m_count()));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_udf));
        check("rd_valid",   32'(rd_valid),   32'(m_rdv));
`ifdef UART_FIFO_LEVEL_FLAGS_EN
        check("almost_full",  32'(almost_full),  32'(m_af));
        check("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
        if (rd_valid) begin
            check("rd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rd_data", 32'(r_data), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver ----------------
    // Entered 1 time unit after a posedge; leaves 1 time unit after the next.
    task automatic step(input logic wr, input logic rd, input logic fl, input logic clr);
        logic acc_w, acc_r;
        fifo_ptr_t nw, nr, ncnt;
        wr_req = wr; rd_req = rd; flush = fl; err_clr = clr;
        if (wr) w_data = 8'($urandom_range(0, 255));
        #2;
        compare_all();
        acc_w = wr & ~m_full() & ~fl;
        acc_r = rd & ~m_empty() & ~fl;
        nw = fl ? '0 : (acc_w ? fifo_ptr_t'(m_w + 1) : m_w);
        nr = fl ? '0 : (acc_r ? fifo_ptr_t'(m_r + 1) : m_r);
        ncnt = fifo_ptr_t'(nw - nr);
        if (fl) exp_q.delete();
        if (acc_w) exp_q.push_back(w_data);
        @(posedge clk);
        #1;
        m_ovf = (wr & m_full() & ~fl) | (m_ovf & ~clr);
        m_udf = (rd & m_empty() & ~fl) | (m_udf & ~clr);
        m_rdv = acc_r;
        m_w = nw; m_r = nr;
        m_af = (ncnt >= fifo_ptr_t'(UART_FIFO_AF_LEVEL));
        m_ae = (ncnt <= fifo_ptr_t'(UART_FIFO_AE_LEVEL));
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Fill with 16 bytes, then a rejected 17th push
        for (int i = 0; i < 16; i++) begin
            check("push_addr", 32'(ram_w_addr), 32'(i));
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("fill_count", 32'(count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_17th", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_w_addr", 32'(ram_w_addr), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Drain 16 bytes, then a rejected pop
        for (int i = 0; i < 16; i++) begin
            check("pop_addr", 32'(ram_r_addr), 32'(i));
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check("rd_valid_pulse", 32'(rd_valid), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("udf_set", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // count = 5, simultaneous push/pop for 40 cycles across the wrap
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("wrap_count", 32'(count), 32'd5);
        check("wrap_w_addr", 32'(ram_w_addr), 32'd13);
        check("wrap_r_addr", 32'(ram_r_addr), 32'd8);

        // Empty with push+pop: push wins, pop rejected
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("empty_pp_count", 32'(count), 32'd1);
        check("empty_pp_udf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Full with push+pop: pop wins, push rejected
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("full_pp_count", 32'(count), 32'd15);
        check("full_pp_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // count = 9, flush while wr_req is high
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_flush_count", 32'(count), 32'd9);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_no_ovf", 32'(overflow), 32'd0);
        check("flush_no_udf", 32'(underflow), 32'd0);

        // err_clr together with a new overflow: set wins
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Asynchronous reset mid-operation, with a pop in flight
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_r_addr", 32'(ram_r_addr), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill from empty watching the level thresholds
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("lvl_count", 32'(count), 32'(k));
`ifdef UART_FIFO_LEVEL_FLAGS_EN
            check("lvl_af", 32'(almost_full), 32'(k >= 14));
            check("lvl_ae", 32'(almost_empty), 32'(k <= 2));
`endif
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end

        // Finish clean: flush and confirm every byte popped was accounted for
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_fifo_ctrl
